// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer: IDLE/FETCH/ISSUE/HALTED with registered fetch handshake
// Optional overflow detection on sequential wrap is enabled by defining PC_SEQ_FAULT_EN.
module pc_seq #(
   parameter int          PC_W     = 5,
   parameter int unsigned RESET_PC = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] ipc,
   input  logic            jump_en,
   input  logic [PC_W-1:0] jump_addr,
   input  logic            stall,
   input  logic            halt,
   input  logic            resume,
   input  logic            imem_ack,
   output logic [PC_W-1:0] pc,
   output logic            imem_req,
   output logic            instr_valid,
   output logic [1:0]      state,
   output logic            fault
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_ISSUE  = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            imem_req_q, imem_req_d;
   logic            instr_valid_q, instr_valid_d;
   logic            fault_q, fault_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= PC_W'(RESET_PC);
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         imem_req_q    <= imem_req_d;
         instr_valid_q <= instr_valid_d;
         fault_q       <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      case (state_q)
         S_IDLE: begin
            state_d = halt ? S_HALTED : S_FETCH;
         end
         S_FETCH: begin
            // The request stays up until acknowledged; halt/stall cannot cancel it.
            if (imem_ack) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (halt) begin
               state_d = S_HALTED;
            end else if (stall) begin
               state_d = S_ISSUE;
            end else if (jump_en) begin
               pc_d    = jump_addr;
               state_d = S_FETCH;
            end else begin
`ifdef PC_SEQ_FAULT_EN
               if (pc_q == {PC_W{1'b1}}) begin
                  fault_d = 1'b1;
                  state_d = S_HALTED;
               end else begin
                  pc_d    = ipc;
                  state_d = S_FETCH;
               end
`else
               pc_d    = ipc;
               state_d = S_FETCH;
`endif
            end
         end
         S_HALTED: begin
            // A latched overflow keeps the sequencer parked until reset.
            if (resume && !halt && !fault_q) begin
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      imem_req_d    = (state_d == S_FETCH);
      instr_valid_d = (state_d == S_ISSUE);
   end

   assign pc          = pc_q;
   assign state       = state_q;
   assign imem_req    = imem_req_q;
   assign instr_valid = instr_valid_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - scoreboard bench for pc_seq: directed scenarios plus randomized traffic
// Honours PC_SEQ_FAULT_EN the same way as the design.
module tb_pc_seq;

   localparam int PC_W = 5;
   localparam int PC_MAX = (1 << PC_W) - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [PC_W-1:0] ipc = '0;
   logic            jump_en = 1'b0;
   logic [PC_W-1:0] jump_addr = '0;
   logic            stall = 1'b0;
   logic            halt = 1'b0;
   logic            resume = 1'b0;
   logic            imem_ack = 1'b0;
   logic [PC_W-1:0] pc;
   logic            imem_req;
   logic            instr_valid;
   logic [1:0]      state;
   logic            fault;

   pc_seq #(.PC_W(PC_W), .RESET_PC(0)) dut (
      .clk(clk), .rst(rst), .ipc(ipc), .jump_en(jump_en), .jump_addr(jump_addr),
      .stall(stall), .halt(halt), .resume(resume), .imem_ack(imem_ack),
      .pc(pc), .imem_req(imem_req), .instr_valid(instr_valid), .state(state), .fault(fault)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // reference: phase 0 idle, 1 fetching, 2 issuing, 3 halted (spec numbering)
   int m_phase = 0;
   int m_pc    = 0;
   int m_fault = 0;
   logic [9:0] exp_q[$];

   function automatic logic [9:0] pack(input int ph, input int p, input int f);
      logic [9:0] r;
      r = {f[0], (ph == 2) ? 1'b1 : 1'b0, (ph == 1) ? 1'b1 : 1'b0, ph[1:0], p[4:0]};
      return r;
   endfunction

   function automatic logic [9:0] observed();
      return {fault, instr_valid, imem_req, state, pc};
   endfunction

   task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual={f,v,req,st,pc}=%b required=%b", nm, act, exp);
   endtask

   // apply inputs for the next rising edge, predict the outcome, then move to the next falling edge
   task automatic cyc(input bit a, input bit h, input bit s, input bit j, input int ja, input bit r);
      imem_ack  = a;
      halt      = h;
      stall     = s;
      jump_en   = j;
      jump_addr = ja[PC_W-1:0];
      resume    = r;
      ipc       = PC_W'((m_pc + 1) % (PC_MAX + 1));
      case (m_phase)
         0: m_phase = h ? 3 : 1;
         1: if (a) m_phase = 2;
         2: begin
            if (h) m_phase = 3;
            else if (s) m_phase = 2;
            else if (j) begin m_pc = ja % (PC_MAX + 1); m_phase = 1; end
`ifdef PC_SEQ_FAULT_EN
            else if (m_pc == PC_MAX) begin m_fault = 1; m_phase = 3; end
`endif
            else begin m_pc = (m_pc + 1) % (PC_MAX + 1); m_phase = 1; end
         end
         default: if (r && !h && m_fault == 0) m_phase = 1;
      endcase
      exp_q.push_back(pack(m_phase, m_pc, m_fault));
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("async_reset", observed(), 10'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_phase = 0; m_pc = 0; m_fault = 0;
   endtask

   task automatic run_ack(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      logic [9:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle", observed(), e);
         end
      end
   end

   initial begin : stimulus
      repeat (3) @(negedge clk);
      chk("reset_state", observed(), 10'b0);
      rst = 1'b0;

      // pc 0,1,2,3 with instr_valid every other cycle; ack during IDLE is irrelevant
      cyc(1, 0, 0, 0, 0, 0);
      chk("first_fetch", observed(), {1'b0, 1'b0, 1'b1, 2'd1, 5'd0});
      cyc(1, 0, 0, 0, 0, 0);
      chk("first_issue", observed(), {1'b0, 1'b1, 1'b0, 2'd2, 5'd0});
      run_ack(2);
      chk("second_issue", observed(), {1'b0, 1'b1, 1'b0, 2'd2, 5'd1});
      run_ack(6);
      chk("issue_pc4", observed(), {1'b0, 1'b1, 1'b0, 2'd2, 5'd4});
      cyc(1, 0, 0, 1, 17, 0);
      chk("jump_17", observed(), {1'b0, 1'b0, 1'b1, 2'd1, 5'd17});
      run_ack(3);

      // stall at pc 6 for 3 cycles, then halt at pc 9 and resume later
      do_reset();
      run_ack(14);
      chk("issue_pc6", observed(), {1'b0, 1'b1, 1'b0, 2'd2, 5'd6});
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 0);
      chk("stall_hold", observed(), {1'b0, 1'b1, 1'b0, 2'd2, 5'd6});
      cyc(1, 0, 0, 0, 0, 0);
      chk("after_stall", observed(), {1'b0, 1'b0, 1'b1, 2'd1, 5'd7});
      run_ack(5);
      cyc(1, 1, 0, 0, 0, 0);
      chk("halted_pc9", observed(), {1'b0, 1'b0, 1'b0, 2'd3, 5'd9});
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 1);
      chk("halt_beats_resume", observed(), {1'b0, 1'b0, 1'b0, 2'd3, 5'd9});
      cyc(0, 0, 0, 0, 0, 1);
      chk("resume_pc9", observed(), {1'b0, 1'b0, 1'b1, 2'd1, 5'd9});

      // reset during an unacknowledged fetch at pc 12
      do_reset();
      run_ack(25);
      cyc(0, 0, 0, 0, 0, 0);
      chk("fetch_pc12", observed(), {1'b0, 1'b0, 1'b1, 2'd1, 5'd12});
      do_reset();

      // sequential run off the top of the address space
      run_ack(64);
      chk("issue_pc31", observed(), {1'b0, 1'b1, 1'b0, 2'd2, 5'd31});
      cyc(1, 0, 0, 0, 0, 0);
`ifdef PC_SEQ_FAULT_EN
      chk("overflow_fault", observed(), {1'b1, 1'b0, 1'b0, 2'd3, 5'd31});
      cyc(1, 0, 0, 0, 0, 1);
      chk("resume_ignored", observed(), {1'b1, 1'b0, 1'b0, 2'd3, 5'd31});
`else
      chk("overflow_wrap", observed(), {1'b0, 1'b0, 1'b1, 2'd1, 5'd0});
      cyc(1, 0, 0, 0, 0, 1);
`endif

      // jump from the top address never faults
      do_reset();
      run_ack(64);
      cyc(1, 0, 0, 1, 3, 0);
      chk("jump_from_top", observed(), {1'b0, 1'b0, 1'b1, 2'd1, 5'd3});

      // randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         cyc($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             int'($urandom_range(0, PC_MAX)), $urandom_range(0, 2) == 0);
      end

      @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
